alu_exec_ctrl: RTL and testbench

ALU_EXEC_CTRL -- requirements
Module: alu_exec_ctrl

---
 rtl/alu_exec_ctrl.sv | 121 ++++++++++++
 tb/tb_alu_exec_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_ctrl.sv
// Instruction sequencer for an external multi-cycle ALU: decodes one instruction,
// drives registered operands for P_ALU_LATENCY cycles, then writes back result and flags.
module alu_exec_ctrl #(
  parameter int          P_ALU_LATENCY = 1,
  parameter logic [3:0]  P_CMP_OPCODE  = 4'b1011
) (
  input  logic        I_CLK,
  input  logic        I_RESET,
  input  logic [15:0] I_INSTR,
  input  logic        I_INSTR_VALID,
  output logic        O_INSTR_READY,
  output logic [15:0] O_ALU_A,
  output logic [15:0] O_ALU_B,
  output logic [3:0]  O_ALU_OPCODE,
  output logic        O_ALU_ENABLE,
  input  logic [15:0] I_ALU_C,
  input  logic [4:0]  I_ALU_STATUS,
  output logic [4:0]  O_PSR,
  input  logic [3:0]  I_DBG_ADDR,
  output logic [15:0] O_DBG_DATA,
  output logic        O_BUSY
);

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_e;

  localparam logic [1:0] CNT_LAST = 2'(P_ALU_LATENCY - 1);

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [15:0] rf_q [16];
  logic [3:0]  rdest_q;
  logic [15:0] alu_a_q, alu_b_q;
  logic [3:0]  alu_op_q;
  logic        alu_en_q;
  logic [4:0]  psr_q;

  logic        accept, wb_we;
  logic        rtype;
  logic [3:0]  op_dec;
  logic [15:0] b_dec;

  assign rtype  = (I_INSTR[15:12] == 4'h0);
  assign op_dec = rtype ? I_INSTR[7:4] : I_INSTR[15:12];
  assign b_dec  = rtype ? rf_q[I_INSTR[3:0]] : {{8{I_INSTR[7]}}, I_INSTR[7:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    wb_we   = 1'b0;
    case (state_q)
      IDLE: if (I_INSTR_VALID) begin
        accept  = 1'b1;
        cnt_d   = 2'd0;
        state_d = EXEC;
      end
      EXEC: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = 2'd0;
          state_d = WB;
        end
      end
      WB: begin
        wb_we   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Operands are sampled from the register file at accept, so Rdest == Rsrc
  // sees the pre-execution value on both ports.
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      rdest_q  <= 4'h0;
      alu_a_q  <= 16'h0;
      alu_b_q  <= 16'h0;
      alu_op_q <= 4'h0;
      alu_en_q <= 1'b0;
      psr_q    <= 5'h0;
    end else begin
      alu_en_q <= (state_d == EXEC);
      if (accept) begin
        rdest_q  <= I_INSTR[11:8];
        alu_a_q  <= rf_q[I_INSTR[11:8]];
        alu_b_q  <= b_dec;
        alu_op_q <= op_dec;
      end
      if (wb_we) psr_q <= I_ALU_STATUS;
    end
  end

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      for (int i = 0; i < 16; i++) rf_q[i] <= 16'h0;
    end else if (wb_we && (alu_op_q != P_CMP_OPCODE)) begin
      rf_q[rdest_q] <= I_ALU_C;
    end
  end

  assign O_INSTR_READY = (state_q == IDLE) && !I_RESET;
  assign O_BUSY        = (state_q != IDLE) && !I_RESET;
  assign O_ALU_A       = alu_a_q;
  assign O_ALU_B       = alu_b_q;
  assign O_ALU_OPCODE  = alu_op_q;
  assign O_ALU_ENABLE  = alu_en_q;
  assign O_PSR         = psr_q;
  assign O_DBG_DATA    = rf_q[I_DBG_ADDR];

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Bench for alu_exec_ctrl: directed cases plus random instructions checked against
// an architectural model (register array + PSR); a second instance runs latency 3.
module tb_alu_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] instr = 16'h0;
  logic        valid = 1'b0;
  logic [15:0] alu_c = 16'h0;
  logic [4:0]  alu_st = 5'h0;
  logic [3:0]  dbg_addr = 4'h0;

  logic        rdy1, en1, busy1, rdy3, en3, busy3;
  logic [15:0] a1, b1, dbg1, a3, b3, dbg3;
  logic [3:0]  op1, op3;
  logic [4:0]  psr1, psr3;

  always #5 clk = ~clk;

  alu_exec_ctrl u_dut1 (
    .I_CLK(clk), .I_RESET(rst), .I_INSTR(instr), .I_INSTR_VALID(valid),
    .O_INSTR_READY(rdy1), .O_ALU_A(a1), .O_ALU_B(b1), .O_ALU_OPCODE(op1),
    .O_ALU_ENABLE(en1), .I_ALU_C(alu_c), .I_ALU_STATUS(alu_st), .O_PSR(psr1),
    .I_DBG_ADDR(dbg_addr), .O_DBG_DATA(dbg1), .O_BUSY(busy1)
  );

  alu_exec_ctrl #(.P_ALU_LATENCY(3)) u_dut3 (
    .I_CLK(clk), .I_RESET(rst), .I_INSTR(instr), .I_INSTR_VALID(valid),
    .O_INSTR_READY(rdy3), .O_ALU_A(a3), .O_ALU_B(b3), .O_ALU_OPCODE(op3),
    .O_ALU_ENABLE(en3), .I_ALU_C(alu_c), .I_ALU_STATUS(alu_st), .O_PSR(psr3),
    .I_DBG_ADDR(dbg_addr), .O_DBG_DATA(dbg3), .O_BUSY(busy3)
  );

  // Select which instance is under observation.
  bit          u3 = 1'b0;
  logic        m_rdy, m_en, m_busy;
  logic [15:0] m_a, m_b, m_dbg;
  logic [3:0]  m_op;
  logic [4:0]  m_psr;
  assign m_rdy  = u3 ? rdy3  : rdy1;
  assign m_en   = u3 ? en3   : en1;
  assign m_busy = u3 ? busy3 : busy1;
  assign m_a    = u3 ? a3    : a1;
  assign m_b    = u3 ? b3    : b1;
  assign m_dbg  = u3 ? dbg3  : dbg1;
  assign m_op   = u3 ? op3   : op1;
  assign m_psr  = u3 ? psr3  : psr1;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vecs = 0, miss = 0;
  int acc_cyc = 0, last_acc = 0;
  logic [15:0] mdl_rf [16];
  logic [4:0]  mdl_psr;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic mdl_clear();
    for (int i = 0; i < 16; i++) mdl_rf[i] = 16'h0;
    mdl_psr = 5'h0;
  endtask

  task automatic chk_rf(input string tag);
    for (int i = 0; i < 16; i++) begin
      dbg_addr = 4'(i);
      step();
      chk(tag, m_dbg, mdl_rf[i]);
    end
  endtask

  task automatic do_reset();
    valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_rdy_hi", {15'h0, m_rdy}, 16'h0);
    step();
    chk("rst_busy", {15'h0, m_busy}, 16'h0);
    chk("rst_en", {15'h0, m_en}, 16'h0);
    chk("rst_a", m_a, 16'h0);
    chk("rst_b", m_b, 16'h0);
    chk("rst_op", {12'h0, m_op}, 16'h0);
    chk("rst_psr", {11'h0, m_psr}, 16'h0);
    rst = 1'b0;
    #1;
    chk("rdy_after_rst", {15'h0, m_rdy}, 16'h1);
    mdl_clear();
  endtask

  // Presents one instruction, acts as the ALU stub, and checks the whole lifecycle.
  task automatic run(input logic [15:0] ins, input logic [15:0] c, input logic [4:0] s,
                     input bit hold);
    int lat, n;
    logic [3:0]  rd, eop;
    logic [15:0] ea, eb;
    lat = u3 ? 3 : 1;
    rd  = ins[11:8];
    if (ins[15:12] == 4'h0) begin
      eop = ins[7:4];
      eb  = mdl_rf[ins[3:0]];
    end else begin
      eop = ins[15:12];
      eb  = 16'($signed(ins[7:0]));
    end
    ea = mdl_rf[rd];
    instr = ins; valid = 1'b1; alu_c = c; alu_st = s; dbg_addr = rd;
    #1;
    n = 0;
    while (m_rdy !== 1'b1 && n < 20) begin step(); n++; end
    chk("rdy_wait", {15'h0, m_rdy}, 16'h1);
    step();
    last_acc = acc_cyc;
    acc_cyc = cyc;
    if (!hold) valid = 1'b0;
    instr = 16'($urandom);
    chk("alu_op", {12'h0, m_op}, {12'h0, eop});
    chk("alu_a", m_a, ea);
    chk("alu_b", m_b, eb);
    chk("exec_rdy", {15'h0, m_rdy}, 16'h0);
    chk("exec_busy", {15'h0, m_busy}, 16'h1);
    n = 0;
    while (m_en === 1'b1 && n < 10) begin
      step(); n++;
      if (m_en === 1'b1) chk("alu_b_hold", m_b, eb);
    end
    chk("en_cycles", 16'(n), 16'(lat));
    chk("wb_dbg_pre", m_dbg, mdl_rf[rd]);
    chk("wb_busy", {15'h0, m_busy}, 16'h1);
    step();
    if (eop != 4'hB) mdl_rf[rd] = c;
    mdl_psr = s;
    chk("ready_lat", 16'(cyc - acc_cyc), 16'(lat + 1));
    chk("rdy_back", {15'h0, m_rdy}, 16'h1);
    chk("wb_dbg_new", m_dbg, mdl_rf[rd]);
    chk("psr", {11'h0, m_psr}, {11'h0, mdl_psr});
  endtask

  initial begin
    step();
    do_reset();
    chk_rf("rst_rf");

    run(16'h51FB, 16'hFFFB, 5'b10000, 1'b0);
    run(16'h1203, 16'h0003, 5'b00000, 1'b0);
    run(16'h1504, 16'h0004, 5'b00000, 1'b0);
    run(16'h0215, 16'h0007, 5'b00001, 1'b0);
    dbg_addr = 4'h5; step();
    chk("r5_unchanged", m_dbg, 16'h0004);
    run(16'h0B31, 16'h1234, 5'b00010, 1'b0);
    dbg_addr = 4'h3; step();
    chk("r3_unchanged", m_dbg, 16'h0000);
    run(16'h0444, 16'h00AA, 5'b00100, 1'b0);

    for (int k = 0; k < 40; k++)
      run(16'($urandom), 16'($urandom), 5'($urandom), 1'b0);
    chk_rf("rand_rf");

    u3 = 1'b1;
    step();
    do_reset();
    run(16'h2104, 16'h0010, 5'b01000, 1'b1);
    run(16'h3102, 16'h0020, 5'b00011, 1'b0);
    chk("accept_gap", 16'(acc_cyc - last_acc), 16'd5);

    instr = 16'h1705; valid = 1'b1; dbg_addr = 4'h7;
    step();
    valid = 1'b0;
    chk("abort_busy", {15'h0, m_busy}, 16'h1);
    step();
    rst = 1'b1;
    #1;
    chk("abort_rdy", {15'h0, m_rdy}, 16'h0);
    chk("abort_busy_rst", {15'h0, m_busy}, 16'h0);
    step();
    chk("abort_en", {15'h0, m_en}, 16'h0);
    chk("abort_a", m_a, 16'h0);
    chk("abort_op", {12'h0, m_op}, 16'h0);
    chk("abort_psr", {11'h0, m_psr}, 16'h0);
    rst = 1'b0;
    #1;
    mdl_clear();
    chk("abort_rdy_after", {15'h0, m_rdy}, 16'h1);
    step(); step(); step();
    chk("abort_psr_later", {11'h0, m_psr}, 16'h0);
    chk_rf("abort_rf");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
